// File: rtl/multi_toggle_pkg.sv
// Shared types and constants for the multi-channel toggle/strobe generator.
package multi_toggle_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned CH_IDX_W  = 4;
  // Upper bound on CNT_W; cfg buses carry div zero-extended to this width.
  localparam int unsigned MAX_CNT_W = 32;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] div;
    logic                 mode;
  } ch_cfg_t;

endpackage

// File: rtl/multi_toggle_gen_if.sv
// Control/config/output bundle of multi_toggle_gen.
interface multi_toggle_gen_if
  import multi_toggle_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [NUM_CH-1:0]   ch_en;
  logic                sync;
  logic                cfg_we;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [CNT_W-1:0]    cfg_div;
  logic                cfg_mode;
  logic [NUM_CH-1:0]   dout;
  logic [NUM_CH-1:0]   tick;
  logic                holding;

  modport master (
    output ch_en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  dout, tick, holding
  );

  modport slave (
    input  ch_en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output dout, tick, holding
  );
endinterface

// File: rtl/multi_toggle_ch.sv
// One generator channel: divide counter, active/shadow config and registered outputs.
module multi_toggle_ch
  import multi_toggle_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    hold_i,
  input  logic    sync_i,
  input  logic    en_i,
  input  logic    we_i,
  input  ch_cfg_t cfg_i,
  output logic    dout_o,
  output logic    tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_cfg_t          act_q, act_d;
  ch_cfg_t          shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             dout_q, dout_d;
  logic             tick_q, tick_d;
  logic             evt;
  logic             apply;

  assign evt = (MAX_CNT_W'(cnt_q) == act_q.div);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    dout_d = dout_q;
    tick_d = 1'b0;
    apply  = 1'b0;
    if (hold_i) begin
      cnt_d  = '0;
      dout_d = 1'b0;
      if (we_i) begin
        act_d  = cfg_i;
        pend_d = 1'b0;
      end
    end else begin
      if (sync_i) begin
        cnt_d  = '0;
        dout_d = 1'b0;
        apply  = pend_q;
      end else if (en_i) begin
        tick_d = evt;
        cnt_d  = evt ? '0 : cnt_q + CNT_W'(1);
        // Output uses the mode active before any same-edge apply.
        if (act_q.mode == MODE_PULSE) begin
          dout_d = evt;
        end else if (evt) begin
          dout_d = ~dout_q;
        end
        apply = pend_q & evt;
      end else begin
        apply = pend_q;
        if (pend_q) begin
          cnt_d = '0;
        end
      end

      if (apply) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end

      // A write landing on an apply/sync edge bypasses the shadow.
      if (we_i) begin
        if (apply || sync_i) begin
          act_d  = cfg_i;
          pend_d = 1'b0;
        end else begin
          shd_d  = cfg_i;
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= '{div: '0, mode: MODE_TOGGLE};
      shd_q  <= '{div: '0, mode: MODE_TOGGLE};
      pend_q <= 1'b0;
      dout_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      dout_q <= dout_d;
      tick_q <= tick_d;
    end
  end

  assign dout_o = dout_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/multi_toggle_gen.sv
// Multi-channel toggle/strobe generator: post-reset hold window, cfg decode, channel array.
module multi_toggle_gen
  import multi_toggle_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  multi_toggle_gen_if.slave bus
);

  localparam logic [3:0] HoldInit    = 4'(HOLD_CYCLES);
  localparam logic       HoldingInit = (HOLD_CYCLES != 0);

  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              holding_q, holding_d;
  logic              hold;
  logic              cfg_valid;
  ch_cfg_t           cfg_w;
  logic [NUM_CH-1:0] dout_w;
  logic [NUM_CH-1:0] tick_w;

  assign hold = (hold_cnt_q != 4'd0);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    holding_d  = holding_q;
    if (hold) begin
      hold_cnt_d = hold_cnt_q - 4'd1;
      holding_d  = (hold_cnt_q != 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= HoldInit;
      holding_q  <= HoldingInit;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      holding_q  <= holding_d;
    end
  end

  // Out-of-range channel indices are dropped, never aliased.
  assign cfg_valid  = (32'(bus.cfg_ch) < NUM_CH);
  assign cfg_w.div  = MAX_CNT_W'(bus.cfg_div);
  assign cfg_w.mode = bus.cfg_mode;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = bus.cfg_we & cfg_valid & (bus.cfg_ch == CH_IDX_W'(i));

    multi_toggle_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .hold_i (hold),
      .sync_i (bus.sync),
      .en_i   (bus.ch_en[i]),
      .we_i   (ch_we),
      .cfg_i  (cfg_w),
      .dout_o (dout_w[i]),
      .tick_o (tick_w[i])
    );
  end

  assign bus.dout    = dout_w;
  assign bus.tick    = tick_w;
  assign bus.holding = holding_q;

endmodule

// File: tb/tb_multi_toggle_gen.sv
// Directed bench for multi_toggle_gen: NUM_CH=4, CNT_W=8, HOLD_CYCLES=1.
module tb_multi_toggle_gen;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned HOLD_CYCLES = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_toggle_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  multi_toggle_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int dv, input logic md);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 4'(ch);
    bus.cfg_div  = 8'(dv);
    bus.cfg_mode = md;
  endtask

  logic [3:0] run_dout  [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0111,
                                4'b0010, 4'b0001, 4'b0000, 4'b0101};
  logic [3:0] run_tick  [8] = '{4'b0001, 4'b0001, 4'b0011, 4'b0101,
                                4'b0001, 4'b0011, 4'b0001, 4'b0101};
  logic [3:0] sync_dout [6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b1110};
  logic [3:0] sync_tick [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111};

  initial begin
    rst          = 1'b1;
    bus.ch_en    = '0;
    bus.sync     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_div  = '0;
    bus.cfg_mode = 1'b0;
    step();
    step();
    check_eq("reset_dout", 32'(bus.dout), 32'h0);
    check_eq("reset_tick", 32'(bus.tick), 32'h0);
    check_eq("reset_holding", 32'(bus.holding), 32'h1);

    // Hold edge: ch1 write lands directly in active.
    rst       = 1'b0;
    bus.ch_en = 4'b0001;
    cfg(1, 2, 1'b0);
    step();
    check_eq("hold_holding", 32'(bus.holding), 32'h0);
    check_eq("hold_dout", 32'(bus.dout), 32'h0);

    cfg(2, 3, 1'b1);
    step();
    check_eq("tog0_a", 32'(bus.dout[0]), 32'h1);
    bus.cfg_we = 1'b0;
    step();
    check_eq("tog0_b", 32'(bus.dout[0]), 32'h0);
    step();
    check_eq("tog0_c", 32'(bus.dout[0]), 32'h1);

    bus.ch_en = 4'b0111;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("run_dout_%0d", i), 32'(bus.dout), 32'(run_dout[i]));
      check_eq($sformatf("run_tick_%0d", i), 32'(bus.tick), 32'(run_tick[i]));
    end

    // Shadow apply on ch1, last of two writes wins.
    step();
    check_eq("shd_evt", 32'(bus.dout[1]), 32'h1);
    cfg(1, 5, 1'b0);
    step();
    cfg(1, 0, 1'b0);
    step();
    check_eq("shd_old_period", 32'(bus.dout[1]), 32'h1);
    bus.cfg_we = 1'b0;
    step();
    check_eq("shd_apply_dout", 32'(bus.dout[1]), 32'h0);
    check_eq("shd_apply_tick", 32'(bus.tick[1]), 32'h1);
    step();
    check_eq("shd_fast_dout", 32'(bus.dout[1]), 32'h1);
    check_eq("shd_fast_tick", 32'(bus.tick[1]), 32'h1);

    // Disabled apply.
    bus.ch_en = 4'b0101;
    cfg(1, 5, 1'b0);
    step();
    check_eq("dis_wr_dout", 32'(bus.dout[1]), 32'h1);
    check_eq("dis_wr_tick", 32'(bus.tick[1]), 32'h0);
    bus.cfg_we = 1'b0;
    step();
    check_eq("dis_apply_dout", 32'(bus.dout[1]), 32'h1);
    check_eq("dis_apply_tick", 32'(bus.tick[1]), 32'h0);
    bus.ch_en = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("reen_tick_%0d", i), 32'(bus.tick[1]), 32'(i == 5));
      check_eq($sformatf("reen_dout_%0d", i), 32'(bus.dout[1]), 32'(i != 5));
    end

    // Sync with a same-edge write to ch2.
    cfg(3, 5, 1'b0);
    step();
    bus.cfg_we = 1'b0;
    step();
    bus.ch_en = 4'b1111;
    step();
    bus.sync = 1'b1;
    cfg(2, 5, 1'b0);
    step();
    check_eq("sync_dout", 32'(bus.dout), 32'h0);
    check_eq("sync_tick", 32'(bus.tick), 32'h0);
    bus.sync   = 1'b0;
    bus.cfg_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("align_dout_%0d", i), 32'(bus.dout), 32'(sync_dout[i]));
      check_eq($sformatf("align_tick_%0d", i), 32'(bus.tick), 32'(sync_tick[i]));
    end

    // Out-of-range index must not touch any channel.
    cfg(7, 0, 1'b1);
    step();
    bus.cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) step();
    step();
    check_eq("badidx_dout_a", 32'(bus.dout), 32'h0);
    check_eq("badidx_tick_a", 32'(bus.tick), 32'hf);
    step();
    check_eq("badidx_dout_b", 32'(bus.dout), 32'h1);
    check_eq("badidx_tick_b", 32'(bus.tick), 32'h1);

    // Reset with a pending write on ch1.
    cfg(1, 3, 1'b0);
    step();
    bus.cfg_we = 1'b0;
    rst        = 1'b1;
    step();
    check_eq("rst2_dout", 32'(bus.dout), 32'h0);
    check_eq("rst2_tick", 32'(bus.tick), 32'h0);
    check_eq("rst2_holding", 32'(bus.holding), 32'h1);
    rst       = 1'b0;
    bus.ch_en = 4'b0010;
    step();
    check_eq("rst2_hold_dout", 32'(bus.dout), 32'h0);
    check_eq("rst2_hold_holding", 32'(bus.holding), 32'h0);
    step();
    check_eq("rst2_run_a", 32'(bus.dout), 32'h2);
    step();
    check_eq("rst2_run_b", 32'(bus.dout), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
